// File: rtl/cpu32_mem_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu32_mem_pkg
// Brief  : Shared definitions for the mem_master CPU-to-RAM request engine:
//          FSM state encoding and default widths / timeout limit.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu32_mem_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TMO_CYC_DEF = 64;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True while a RAM transaction is outstanding.
    function automatic logic st_busy(input state_e s);
        return (s == ST_ISSUE) || (s == ST_WAIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wdt.sv
//------------------------------------------------------------------------------
// Module : mem_wdt
// Brief  : Transaction watchdog. Counts consecutive cycles with run=1 and
//          flags expired during the TMO_CYC-th such cycle, so the owner can
//          leave its busy state on the edge that ends that cycle.
// Ports  : clk      - rising-edge clock
//          rst_n    - asynchronous active-low reset
//          run      - count enable; low clears the count
//          expired  - high in the last allowed busy cycle
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_wdt
    import cpu32_mem_pkg::*;
#(
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The owner drops run on the edge after expiry, so the count never
    // needs to go past CNT_LAST.
    always_comb begin
        cnt_d = run ? (cnt_q + CNT_W'(1)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_master.sv
//------------------------------------------------------------------------------
// Module : mem_master
// Brief  : Single-outstanding CPU request engine driving a RAM with separate
//          read and write channels. A request is latched in IDLE, the active
//          channels are handshaken (rdy drops, then rises) and a one-cycle
//          completion pulse is issued from DONE.
// Config : `define MEM_MASTER_TIMEOUT_EN to add the mem_wdt watchdog; without
//          it ISSUE/WAIT wait forever and resp_tmo is tied low.
// Ports  : CPU side  req_valid/req_re/req_we/req_raddr/req_waddr/req_wdata in,
//                    req_ready/resp_valid/resp_rdata/resp_exc/resp_tmo out
//          RAM side  r_addr/w_addr/w_line/read/write out,
//                    r_line/rrdy/wrdy/exc in
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_master
    import cpu32_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU side
    input  logic              req_valid,
    input  logic              req_re,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_raddr,
    input  logic [ADDR_W-1:0] req_waddr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_exc,
    output logic              resp_tmo,
    // RAM side
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_line,
    output logic              read,
    output logic              write,
    input  logic [DATA_W-1:0] r_line,
    input  logic              rrdy,
    input  logic              wrdy,
    input  logic              exc
);

    state_e            state_q,  state_d;
    logic [ADDR_W-1:0] raddr_q,  raddr_d;
    logic [ADDR_W-1:0] waddr_q,  waddr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              rd_q,     rd_d;
    logic              wr_q,     wr_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              exc_q,    exc_d;

    // Inactive channels are treated as already satisfied so a single-channel
    // request only depends on its own ready line.
    logic all_lo;
    logic all_hi;

    assign all_lo = (!rd_q || !rrdy) && (!wr_q || !wrdy);
    assign all_hi = (!rd_q ||  rrdy) && (!wr_q ||  wrdy);

`ifdef MEM_MASTER_TIMEOUT_EN
    logic tmo_q, tmo_d;
    logic wdt_run;
    logic wdt_expired;

    assign wdt_run = st_busy(state_q);

    mem_wdt #(
        .TMO_CYC (TMO_CYC)
    ) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (wdt_run),
        .expired (wdt_expired)
    );
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_CYC != 0);
`endif

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
`ifdef MEM_MASTER_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    raddr_d = req_raddr;
                    waddr_d = req_waddr;
                    wdata_d = req_wdata;
                    rd_d    = req_re;
                    wr_d    = req_we;
                    if (req_re || req_we) begin
                        state_d = ST_ISSUE;
                    end else begin
                        // Nothing to do on the RAM: complete cleanly.
                        state_d = ST_DONE;
                        exc_d   = 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
                        tmo_d   = 1'b0;
`endif
                    end
                end
            end

            ST_ISSUE, ST_WAIT: begin
                // Priority: RAM exception, normal completion, timeout,
                // then the ISSUE->WAIT handshake step.
                if (exc) begin
                    state_d = ST_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    exc_d   = 1'b1;
`ifdef MEM_MASTER_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end else if ((state_q == ST_WAIT) && all_hi) begin
                    state_d = ST_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    exc_d   = 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                    if (rd_q) begin
                        rdata_d = r_line;
                    end
`ifdef MEM_MASTER_TIMEOUT_EN
                end else if (wdt_expired) begin
                    state_d = ST_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    exc_d   = 1'b1;
                    tmo_d   = 1'b1;
`endif
                end else if ((state_q == ST_ISSUE) && all_lo) begin
                    state_d = ST_WAIT;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

`ifdef MEM_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign resp_tmo = tmo_q;
`else
    assign resp_tmo = 1'b0;
`endif

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_rdata = rdata_q;
    assign resp_exc   = exc_q;
    assign r_addr     = raddr_q;
    assign w_addr     = waddr_q;
    assign w_line     = wdata_q;
    assign read       = rd_q;
    assign write      = wr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_master.sv
//------------------------------------------------------------------------------
// Module : tb_mem_master
// Brief  : Self-checking bench for mem_master. A transaction-level model of
//          the request engine is compared against every DUT output on each
//          falling clock edge; directed transactions add literal checks of
//          latency and response fields.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_master;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned TB_TMO = 8;
`ifdef MEM_MASTER_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_re, req_we;
    logic [AW-1:0] req_raddr, req_waddr;
    logic [DW-1:0] req_wdata;
    logic          req_ready, resp_valid, resp_exc, resp_tmo;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] w_line, r_line;
    logic          read, write, rrdy, wrdy, exc;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TMO_CYC (TB_TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_re     (req_re),
        .req_we     (req_we),
        .req_raddr  (req_raddr),
        .req_waddr  (req_waddr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_exc   (resp_exc),
        .resp_tmo   (resp_tmo),
        .r_addr     (r_addr),
        .w_addr     (w_addr),
        .w_line     (w_line),
        .read       (read),
        .write      (write),
        .r_line     (r_line),
        .rrdy       (rrdy),
        .wrdy       (wrdy),
        .exc        (exc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // busy    : a RAM transaction is outstanding
    // dropped : all active channels have been seen not-ready once
    // done    : the completion cycle
    bit          m_busy, m_dropped, m_done, m_re, m_we, m_exc, m_tmo;
    logic [31:0] m_raddr, m_waddr, m_wdata, m_rdata;
    int          m_age;

    wire m_all_lo = (!m_re || !rrdy) && (!m_we || !wrdy);
    wire m_all_hi = (!m_re ||  rrdy) && (!m_we ||  wrdy);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_dropped <= 0; m_done <= 0; m_re <= 0; m_we <= 0;
            m_exc <= 0; m_tmo <= 0; m_raddr <= 0; m_waddr <= 0; m_wdata <= 0;
            m_rdata <= 0; m_age <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_raddr <= req_raddr; m_waddr <= req_waddr; m_wdata <= req_wdata;
                m_re <= req_re; m_we <= req_we;
                if (req_re || req_we) begin
                    m_busy <= 1; m_dropped <= 0; m_age <= 0;
                end else begin
                    m_done <= 1; m_exc <= 0; m_tmo <= 0;
                end
            end
        end else begin
            m_age <= m_age + 1;
            if (exc) begin
                m_busy <= 0; m_done <= 1; m_exc <= 1; m_tmo <= 0;
            end else if (m_dropped && m_all_hi) begin
                m_busy <= 0; m_done <= 1; m_exc <= 0; m_tmo <= 0;
                if (m_re) m_rdata <= r_line;
            end else if (TMO_ON && (m_age + 1 >= TB_TMO)) begin
                m_busy <= 0; m_done <= 1; m_exc <= 1; m_tmo <= 1;
            end else if (m_all_lo) begin
                m_dropped <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",  req_ready,  !m_busy && !m_done);
            chk("resp_valid", resp_valid, m_done);
            chk("read",       read,       m_busy && m_re);
            chk("write",      write,      m_busy && m_we);
            chk("r_addr",     r_addr,     m_raddr);
            chk("w_addr",     w_addr,     m_waddr);
            chk("w_line",     w_line,     m_wdata);
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("resp_exc",   resp_exc,   m_exc);
            chk("resp_tmo",   resp_tmo,   m_tmo);
        end
    end

    // ---------------- stimulus ----------------
    // Cycle k (k>=1) is the cycle that starts k-1 edges after the accept edge.
    // rdy lines are low during [lo,hi], exc pulses in cycle exc_cyc, r_line
    // carries rl from cycle rl_from on. lat = cycle holding resp_valid, -1 if
    // none within max_cyc (inputs are then left as in the last cycle).
    task automatic run_txn(input bit re, input bit we,
                           input logic [31:0] raddr, input logic [31:0] waddr,
                           input logic [31:0] wdata,
                           input int r_lo, input int r_hi, input int w_lo, input int w_hi,
                           input int exc_cyc, input logic [31:0] rl, input int rl_from,
                           input int max_cyc, output int lat);
        @(posedge clk); #1;
        req_valid = 1; req_re = re; req_we = we;
        req_raddr = raddr; req_waddr = waddr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 0;
        lat = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            rrdy   = !(k >= r_lo && k <= r_hi);
            wrdy   = !(k >= w_lo && k <= w_hi);
            exc    = (k == exc_cyc);
            r_line = (k >= rl_from) ? rl : 32'hDEAD_BEEF;
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            rrdy = 1; wrdy = 1; exc = 0;
        end
    endtask

    int lat;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1; req_valid = 0; req_re = 0; req_we = 0;
        req_raddr = 0; req_waddr = 0; req_wdata = 0;
        r_line = 0; rrdy = 1; wrdy = 1; exc = 0;
        #3 rst_n = 0;
        chk_en = 1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("reset_ready", req_ready, 1);
        chk("reset_read",  read, 0);

        // Write only: wrdy low cycles 1..3
        run_txn(0, 1, 32'h0, 32'h10, 32'hA5, 0, -1, 1, 3, 0, 32'h0, 99, 20, lat);
        chk("wr_latency", lat, 5);
        chk("wr_exc",     resp_exc, 0);
        chk("wr_addr",    w_addr, 32'h10);
        chk("wr_line",    w_line, 32'hA5);

        // Read + write: rrdy back in cycle 3, wrdy in cycle 5
        run_txn(1, 1, 32'h5, 32'h6, 32'h77, 1, 2, 1, 4, 0, 32'h0A, 3, 20, lat);
        chk("rw_latency", lat, 6);
        chk("rw_rdata",   resp_rdata, 32'h0A);
        chk("rw_exc",     resp_exc, 0);

        // Exception in ISSUE
        run_txn(1, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, -1, 0, -1, 1, 32'h55, 1, 20, lat);
        chk("exc_latency", lat, 2);
        chk("exc_flag",    resp_exc, 1);
        chk("exc_rdata",   resp_rdata, 32'h0A);
        chk("exc_read",    read, 0);

        // Null op
        run_txn(0, 0, 32'h3, 32'h4, 32'h9, 0, -1, 0, -1, 0, 32'h0, 99, 20, lat);
        chk("null_latency", lat, 1);
        chk("null_exc",     resp_exc, 0);

        // Reset while in WAIT
        run_txn(1, 1, 32'h20, 32'h24, 32'h11, 1, 999, 1, 999, 0, 32'h0, 99, 3, lat);
        chk("rst_noresp", lat, -1);
        chk("rst_busy_read", read, 1);
        rst_n = 0;
        #1;
        chk("rst_read",  read, 0);
        chk("rst_write", write, 0);
        chk("rst_valid", resp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1; rrdy = 1; wrdy = 1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);

        // Normal read after reset
        run_txn(1, 0, 32'h30, 32'h0, 32'h0, 1, 1, 0, -1, 0, 32'h1234, 1, 20, lat);
        chk("post_latency", lat, 3);
        chk("post_rdata",   resp_rdata, 32'h1234);

        // rrdy stuck high: timeout or infinite wait
        run_txn(1, 0, 32'h40, 32'h0, 32'h0, 0, -1, 0, -1, 0, 32'h0, 99, 100, lat);
`ifdef MEM_MASTER_TIMEOUT_EN
        chk("tmo_latency", lat, 9);
        chk("tmo_exc",     resp_exc, 1);
        chk("tmo_flag",    resp_tmo, 1);
`else
        chk("tmo_noresp",  lat, -1);
        chk("tmo_flag",    resp_tmo, 0);
`endif
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1; rrdy = 1; wrdy = 1; exc = 0;
        @(negedge clk);
        chk("end_ready", req_ready, 1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
